// File: rtl/rs_branch_pkg.sv
// Shared types for the branch reservation station and branch FU: micro-op payload,
// ROB geometry, BNE/JALR encodings and the ROB-relative age helper.
package rs_branch_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = 5;
  localparam int RS_PREG_W = 7;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_JALR    = 3'b000;

  typedef struct packed {
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic                 ps1_ready;
    logic                 ps2_ready;
    logic [ROB_IDX_W-1:0] rob_index;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [RS_PREG_W-1:0] pd;
  } rs_data;

  // Distance from the ROB head; relies on 5-bit wrap so smaller means older.
  function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                   input logic [ROB_IDX_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/rs_branch_if.sv
// Dispatch / wakeup / issue / flush bundle of the branch reservation station.
interface rs_branch_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int PREG_W  = 7
);
  import rs_branch_pkg::*;

  logic                            disp_valid;
  rs_data                          disp_data;
  logic                            disp_ready;
  logic [NUM_CDB-1:0]              cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0]  cdb_tag;
  logic                            fu_b_ready;
  logic                            issued;
  rs_data                          data_out;
  logic [ROB_IDX_W-1:0]            curr_rob_tag;
  logic                            mispredict;
  logic [ROB_IDX_W-1:0]            mispredict_tag;
  logic [$clog2(DEPTH):0]          count;

  modport master (
    output disp_valid, disp_data, cdb_valid, cdb_tag, fu_b_ready,
           curr_rob_tag, mispredict, mispredict_tag,
    input  disp_ready, issued, data_out, count
  );

  modport slave (
    input  disp_valid, disp_data, cdb_valid, cdb_tag, fu_b_ready,
           curr_rob_tag, mispredict, mispredict_tag,
    output disp_ready, issued, data_out, count
  );

endinterface

// File: rtl/rs_branch_age_select.sv
// rs_age_select: combinational oldest-ready picker; age is measured from the ROB head.
module rs_age_select
  import rs_branch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         cand,
  input  logic [ROB_IDX_W-1:0]     rob_idx [DEPTH],
  input  logic [ROB_IDX_W-1:0]     curr_rob_tag,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] grant_idx
);

  logic [ROB_IDX_W-1:0] best_age;
  logic [ROB_IDX_W-1:0] age_i;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    best_age  = '1;
    age_i     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_i = rob_age(rob_idx[i], curr_rob_tag);
      if (cand[i] && (!found || age_i < best_age)) begin
        found     = 1'b1;
        grant_idx = ($clog2(DEPTH))'(i);
        best_age  = age_i;
      end
    end
  end

endmodule

// File: rtl/rs_branch.sv
// rs_branch: branch/jump reservation station, CDB wakeup, oldest-ready issue, mispredict squash.
// Build option: define BRANCH_RS_WAKEUP_BYPASS_EN to fold same-cycle CDB hits into dispatched ready bits.
module rs_branch
  import rs_branch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int PREG_W  = RS_PREG_W
) (
  input  logic       clk,
  input  logic       reset,
  rs_branch_if.slave rs
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_data               entry [DEPTH];
  logic [DEPTH-1:0]     valid, r1, r2;
  logic [DEPTH-1:0]     valid_nxt, r1_nxt, r2_nxt;
  logic [CNT_W-1:0]     count_q;
  logic                 issued_q;
  rs_data               data_out_q;

  logic [DEPTH-1:0]     cand;
  logic [ROB_IDX_W-1:0] rob_idx [DEPTH];
  logic                 found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 disp_fire, issue_fire, sel_squashed;
  logic                 disp_r1, disp_r2;

  function automatic logic tag_hit(input logic [PREG_W-1:0]               tag,
                                   input logic [NUM_CDB-1:0]              v,
                                   input logic [NUM_CDB-1:0][PREG_W-1:0]  tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      hit = hit | (v[k] && (tags[k] == tag));
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++)
      n = n + CNT_W'(m[i]);
    return n;
  endfunction

  function automatic logic is_younger(input logic [ROB_IDX_W-1:0] idx,
                                      input logic [ROB_IDX_W-1:0] flush_idx,
                                      input logic [ROB_IDX_W-1:0] head);
    return rob_age(idx, head) > rob_age(flush_idx, head);
  endfunction

  // Select stage: registered ready bits feed the age picker.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i]    = valid[i] & r1[i] & r2[i];
      rob_idx[i] = entry[i].rob_index;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .cand         (cand),
    .rob_idx      (rob_idx),
    .curr_rob_tag (rs.curr_rob_tag),
    .found        (found),
    .grant_idx    (grant_idx)
  );

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

  assign rs.disp_ready = (count_q != CNT_W'(DEPTH));
  assign disp_fire     = rs.disp_valid && rs.disp_ready && !rs.mispredict;
  assign sel_squashed  = rs.mispredict &&
                         is_younger(entry[grant_idx].rob_index, rs.mispredict_tag, rs.curr_rob_tag);
  assign issue_fire    = found && rs.fu_b_ready && !sel_squashed;

`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
  assign disp_r1 = rs.disp_data.ps1_ready | tag_hit(rs.disp_data.ps1, rs.cdb_valid, rs.cdb_tag);
  assign disp_r2 = rs.disp_data.ps2_ready | tag_hit(rs.disp_data.ps2, rs.cdb_valid, rs.cdb_tag);
`else
  assign disp_r1 = rs.disp_data.ps1_ready;
  assign disp_r2 = rs.disp_data.ps2_ready;
`endif

  // Freeing by issue or flush is applied before the new entry lands in a previously free slot.
  always_comb begin
    valid_nxt = valid;
    r1_nxt    = r1;
    r2_nxt    = r2;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        r1_nxt[i] = r1[i] | tag_hit(entry[i].ps1, rs.cdb_valid, rs.cdb_tag);
        r2_nxt[i] = r2[i] | tag_hit(entry[i].ps2, rs.cdb_valid, rs.cdb_tag);
      end
      if (rs.mispredict && is_younger(entry[i].rob_index, rs.mispredict_tag, rs.curr_rob_tag))
        valid_nxt[i] = 1'b0;
    end
    if (issue_fire)
      valid_nxt[grant_idx] = 1'b0;
    if (disp_fire) begin
      valid_nxt[free_idx] = 1'b1;
      r1_nxt[free_idx]    = disp_r1;
      r2_nxt[free_idx]    = disp_r2;
    end
  end

  // Issue stage boundary: entry state, occupancy and issue register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      r1         <= '0;
      r2         <= '0;
      count_q    <= '0;
      issued_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      valid    <= valid_nxt;
      r1       <= r1_nxt;
      r2       <= r2_nxt;
      count_q  <= popcount(valid_nxt);
      issued_q <= issue_fire;
      if (issue_fire)
        data_out_q <= entry[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (disp_fire)
      entry[free_idx] <= rs.disp_data;
  end

  assign rs.issued   = issued_q;
  assign rs.data_out = data_out_q;
  assign rs.count    = count_q;

endmodule

// File: tb/tb_rs_branch.sv
// Directed scoreboard bench for rs_branch; the bypass case follows BRANCH_RS_WAKEUP_BYPASS_EN.
module tb_rs_branch;
  import rs_branch_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  rs_data exp_q[$];

  rs_branch_if #(.DEPTH(8), .NUM_CDB(2), .PREG_W(7)) dut_if ();

  rs_branch #(.DEPTH(8), .NUM_CDB(2), .PREG_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_data mk(input int rob, input int p1, input bit rd1,
                                input int p2, input bit rd2);
    rs_data d;
    d           = '0;
    d.ps1       = 7'(p1);
    d.ps2       = 7'(p2);
    d.ps1_ready = rd1;
    d.ps2_ready = rd2;
    d.rob_index = 5'(rob);
    d.pc        = 32'h1000 + 32'(rob * 4);
    d.imm       = 32'(rob);
    d.Opcode    = (rob % 2 == 1) ? OPC_JALR : OPC_BRANCH;
    d.func3     = (rob % 2 == 1) ? F3_JALR : F3_BNE;
    d.pd        = 7'(rob + 64);
    return d;
  endfunction

  task automatic dispatch(input rs_data d);
    dut_if.disp_valid = 1'b1;
    dut_if.disp_data  = d;
    tick();
    dut_if.disp_valid = 1'b0;
  endtask

  // Scoreboard monitor: every issue pops the next expected micro-op.
  always @(negedge clk) begin
    if (!reset && dut_if.issued) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_issue: got rob %0d, expected no issue", dut_if.data_out.rob_index);
      end else begin
        rs_data e;
        e = exp_q.pop_front();
        chk("issue_rob", 32'(dut_if.data_out.rob_index), 32'(e.rob_index));
        chk("issue_pc", dut_if.data_out.pc, e.pc);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset                 = 1'b1;
    dut_if.disp_valid     = 1'b0;
    dut_if.disp_data      = '0;
    dut_if.cdb_valid      = '0;
    dut_if.cdb_tag        = '0;
    dut_if.fu_b_ready     = 1'b0;
    dut_if.curr_rob_tag   = '0;
    dut_if.mispredict     = 1'b0;
    dut_if.mispredict_tag = '0;

    // Reset state
    tick();
    tick();
    chk("rst_count", 32'(dut_if.count), 0);
    chk("rst_issued", 32'(dut_if.issued), 0);
    chk("rst_data_out_nonzero", 32'(dut_if.data_out != '0), 0);
    reset = 1'b0;
    tick();
    chk("rst_disp_ready", 32'(dut_if.disp_ready), 1);

    // Both sources ready: issue two cycles after dispatch
    dut_if.fu_b_ready = 1'b1;
    exp_q.push_back(mk(3, 1, 1, 2, 1));
    dispatch(mk(3, 1, 1, 2, 1));
    chk("lat_t1_issued", 32'(dut_if.issued), 0);
    chk("lat_t1_count", 32'(dut_if.count), 1);
    tick();
    chk("lat_t2_issued", 32'(dut_if.issued), 1);
    chk("lat_t2_count", 32'(dut_if.count), 0);
    tick();
    chk("lat_pulse", 32'(dut_if.issued), 0);

    // Wakeup via CDB port 1
    dispatch(mk(4, 12, 0, 9, 1));
    dut_if.cdb_valid  = 2'b01;
    dut_if.cdb_tag[0] = 7'd13;
    tick();
    dut_if.cdb_valid  = 2'b00;
    chk("wake_decoy_issued", 32'(dut_if.issued), 0);
    chk("wake_wait_count", 32'(dut_if.count), 1);
    exp_q.push_back(mk(4, 12, 0, 9, 1));
    dut_if.cdb_valid  = 2'b10;
    dut_if.cdb_tag[1] = 7'd12;
    tick();
    dut_if.cdb_valid  = 2'b00;
    chk("wake_t1_issued", 32'(dut_if.issued), 0);
    tick();
    chk("wake_t2_issued", 32'(dut_if.issued), 1);

    // Wrap-around age ordering from head 30
    dut_if.fu_b_ready   = 1'b0;
    dut_if.curr_rob_tag = 5'd30;
    dispatch(mk(1, 0, 1, 0, 1));
    dispatch(mk(31, 0, 1, 0, 1));
    dispatch(mk(5, 0, 1, 0, 1));
    chk("age_count", 32'(dut_if.count), 3);
    exp_q.push_back(mk(31, 0, 1, 0, 1));
    exp_q.push_back(mk(1, 0, 1, 0, 1));
    exp_q.push_back(mk(5, 0, 1, 0, 1));
    dut_if.fu_b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("age_issued", 32'(dut_if.issued), 1);
    end
    chk("age_drained", 32'(dut_if.count), 0);

    // Fill, then stall the FU
    dut_if.fu_b_ready   = 1'b0;
    dut_if.curr_rob_tag = 5'd0;
    for (int i = 0; i < 8; i++) dispatch(mk(8 + i, 0, 1, 0, 1));
    chk("full_count", 32'(dut_if.count), 8);
    chk("full_disp_ready", 32'(dut_if.disp_ready), 0);
    dut_if.disp_valid = 1'b1;
    dut_if.disp_data  = mk(16, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_issued", 32'(dut_if.issued), 0);
      chk("stall_count", 32'(dut_if.count), 8);
    end
    dut_if.disp_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(8 + i, 0, 1, 0, 1));
    dut_if.fu_b_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("full_issued", 32'(dut_if.issued), 1);
    end
    chk("full_drained", 32'(dut_if.count), 0);
    chk("full_disp_ready_back", 32'(dut_if.disp_ready), 1);

    // Mispredict squash of younger entries, dispatch dropped
    dut_if.fu_b_ready = 1'b0;
    dispatch(mk(2, 0, 1, 0, 1));
    dispatch(mk(4, 0, 1, 0, 1));
    dispatch(mk(6, 0, 1, 0, 1));
    dut_if.mispredict     = 1'b1;
    dut_if.mispredict_tag = 5'd3;
    dut_if.disp_valid     = 1'b1;
    dut_if.disp_data      = mk(7, 0, 1, 0, 1);
    tick();
    dut_if.mispredict = 1'b0;
    dut_if.disp_valid = 1'b0;
    chk("flush_count", 32'(dut_if.count), 1);
    exp_q.push_back(mk(2, 0, 1, 0, 1));
    dut_if.fu_b_ready = 1'b1;
    tick();
    chk("flush_survivor_issued", 32'(dut_if.issued), 1);
    chk("flush_empty", 32'(dut_if.count), 0);

    // Selected entry squashed in its issue cycle
    dut_if.fu_b_ready = 1'b0;
    dispatch(mk(9, 0, 1, 0, 1));
    dut_if.fu_b_ready     = 1'b1;
    dut_if.mispredict     = 1'b1;
    dut_if.mispredict_tag = 5'd8;
    tick();
    dut_if.mispredict = 1'b0;
    chk("squash_sel_issued", 32'(dut_if.issued), 0);
    chk("squash_sel_count", 32'(dut_if.count), 0);
    tick();
    chk("squash_sel_later", 32'(dut_if.issued), 0);

    // Same-cycle broadcast at dispatch
    dut_if.disp_valid = 1'b1;
    dut_if.disp_data  = mk(20, 5, 1, 40, 0);
    dut_if.cdb_valid  = 2'b01;
    dut_if.cdb_tag[0] = 7'd40;
    tick();
    dut_if.disp_valid = 1'b0;
    dut_if.cdb_valid  = 2'b00;
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
    exp_q.push_back(mk(20, 5, 1, 40, 0));
    chk("byp_t1_issued", 32'(dut_if.issued), 0);
    tick();
    chk("byp_t2_issued", 32'(dut_if.issued), 1);
    chk("byp_count", 32'(dut_if.count), 0);
`else
    chk("nobyp_t1_issued", 32'(dut_if.issued), 0);
    tick();
    chk("nobyp_t2_issued", 32'(dut_if.issued), 0);
    chk("nobyp_count", 32'(dut_if.count), 1);
    exp_q.push_back(mk(20, 5, 1, 40, 0));
    dut_if.cdb_valid  = 2'b01;
    dut_if.cdb_tag[0] = 7'd40;
    tick();
    dut_if.cdb_valid  = 2'b00;
    chk("nobyp_late_t1", 32'(dut_if.issued), 0);
    tick();
    chk("nobyp_late_t2", 32'(dut_if.issued), 1);
    chk("nobyp_drained", 32'(dut_if.count), 0);
`endif

    tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
